// File: rtl/lms_grad_calc_pkg.sv
// Shared definitions for the LMS gradient calculator.
//   LMS_NTAP / LMS_DW / LMS_SHIFT : default delay-line depth, sample width and
//                                   product-sum right shift
//   TAP_W                         : tap-index width
//   SAT_MAX / SAT_MIN             : gradient saturation limits (DW-bit signed)
//   state_t                       : sweep controller states
package lms_grad_calc_pkg;

   localparam int LMS_NTAP  = 32;
   localparam int LMS_DW    = 16;
   localparam int LMS_SHIFT = 15;

   localparam int TAP_W = $clog2(LMS_NTAP);

   localparam int SAT_MAX = (2 ** (LMS_DW - 1)) - 1;
   localparam int SAT_MIN = -(2 ** (LMS_DW - 1));

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SWEEP,
      ST_DRAIN
   } state_t;

endpackage

// File: rtl/cmul_conj_sat.sv
// Two-stage pipelined e*conj(x) with arithmetic shift and saturation.
//   clk, reset          : clock, asynchronous active-low reset
//   in_valid, in_tag    : operand strobe and sideband tag (tap index)
//   e_i, e_q, x_i, x_q  : error and sample operands
//   out_valid, out_tag  : delayed strobe/tag, aligned with the result
//   out_i, out_q        : saturated result, forced to 0 when out_valid=0
module cmul_conj_sat
   import lms_grad_calc_pkg::*;
#(
   parameter int DW    = LMS_DW,
   parameter int SHIFT = LMS_SHIFT,
   parameter int TW    = TAP_W
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   input  logic [TW-1:0]        in_tag,
   input  logic signed [DW-1:0] e_i,
   input  logic signed [DW-1:0] e_q,
   input  logic signed [DW-1:0] x_i,
   input  logic signed [DW-1:0] x_q,
   output logic                 out_valid,
   output logic [TW-1:0]        out_tag,
   output logic signed [DW-1:0] out_i,
   output logic signed [DW-1:0] out_q
);

   localparam int PW = 2 * DW;
   localparam int SW = 2 * DW + 1;
   localparam logic signed [SW-1:0] HI = SW'(SAT_MAX);
   localparam logic signed [SW-1:0] LO = SW'(SAT_MIN);

   logic signed [PW-1:0] p_ii, p_qq, p_qi, p_iq;
   logic                 v1;
   logic [TW-1:0]        tag1;

   logic signed [SW-1:0] s_re, s_im, sh_re, sh_im;
   logic signed [DW-1:0] sat_re, sat_im;

   function automatic logic signed [DW-1:0] sat_dw(input logic signed [SW-1:0] v);
      if (v > HI)
         return HI[DW-1:0];
      else if (v < LO)
         return LO[DW-1:0];
      else
         return v[DW-1:0];
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         p_ii <= '0;
         p_qq <= '0;
         p_qi <= '0;
         p_iq <= '0;
         v1   <= 1'b0;
         tag1 <= '0;
      end else begin
         p_ii <= e_i * x_i;
         p_qq <= e_q * x_q;
         p_qi <= e_q * x_i;
         p_iq <= e_i * x_q;
         v1   <= in_valid;
         tag1 <= in_tag;
      end
   end

   always_comb begin
      s_re   = SW'(p_ii) + SW'(p_qq);
      s_im   = SW'(p_qi) - SW'(p_iq);
      sh_re  = s_re >>> SHIFT;
      sh_im  = s_im >>> SHIFT;
      sat_re = sat_dw(sh_re);
      sat_im = sat_dw(sh_im);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         out_tag   <= '0;
         out_i     <= '0;
         out_q     <= '0;
      end else begin
         out_valid <= v1;
         out_tag   <= v1 ? tag1 : '0;
         out_i     <= v1 ? sat_re : '0;
         out_q     <= v1 ? sat_im : '0;
      end
   end

endmodule

// File: rtl/lms_grad_calc.sv
// LMS gradient calculator: complex delay line plus latched error; each accepted
// error triggers a sweep streaming e*conj(x[k]) for k = 0..NTAP-1, one per clock.
//   clk, reset                 : clock, asynchronous active-low reset
//   din_i/q, din_valid/ready   : sample input; shifts the line in IDLE only
//   err_i/q, err_valid/ready   : error input; accepted in IDLE, starts a sweep
//   grad_i/q, grad_valid       : gradient term, zero when not valid
//   grad_tap                   : tap index of the current term, zero when invalid
module lms_grad_calc
   import lms_grad_calc_pkg::*;
#(
   parameter int NTAP  = LMS_NTAP,
   parameter int DW    = LMS_DW,
   parameter int SHIFT = LMS_SHIFT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic signed [DW-1:0] din_i,
   input  logic signed [DW-1:0] din_q,
   input  logic                 din_valid,
   output logic                 din_ready,
   input  logic signed [DW-1:0] err_i,
   input  logic signed [DW-1:0] err_q,
   input  logic                 err_valid,
   output logic                 err_ready,
   output logic signed [DW-1:0] grad_i,
   output logic signed [DW-1:0] grad_q,
   output logic                 grad_valid,
   output logic [TAP_W-1:0]     grad_tap
);

   localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NTAP - 1);

   state_t state, state_n;
   logic   ready_q;
   logic   accept_err, shift_en;
   logic   drain_cnt;
   logic [TAP_W-1:0] k;

   logic signed [DW-1:0] x_i [NTAP];
   logic signed [DW-1:0] x_q [NTAP];
   logic signed [DW-1:0] e_i, e_q;

   // Operand register in front of the multiplier; gives the 3-edge latency
   // from error acceptance to the tap-0 term.
   logic                 feed_valid;
   logic [TAP_W-1:0]     feed_tag;
   logic signed [DW-1:0] feed_xi, feed_xq;

   always_comb begin
      state_n    = state;
      accept_err = 1'b0;
      case (state)
         ST_IDLE:
            if (ready_q && err_valid) begin
               accept_err = 1'b1;
               state_n    = ST_SWEEP;
            end
         ST_SWEEP:
            if (k == LAST_TAP)
               state_n = ST_DRAIN;
         ST_DRAIN:
            if (drain_cnt)
               state_n = ST_IDLE;
         default:
            state_n = ST_IDLE;
      endcase
   end

   // ready_q is registered so it stays low until the first clock after reset.
   assign shift_en  = ready_q && din_valid;
   assign din_ready = ready_q;
   assign err_ready = ready_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         ready_q   <= 1'b0;
         k         <= '0;
         drain_cnt <= 1'b0;
      end else begin
         state     <= state_n;
         ready_q   <= (state_n == ST_IDLE);
         if (accept_err)
            k <= '0;
         else if (state == ST_SWEEP)
            k <= k + 1'b1;
         drain_cnt <= (state == ST_DRAIN) ? ~drain_cnt : 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned n = 0; n < NTAP; n++) begin
            x_i[n] <= '0;
            x_q[n] <= '0;
         end
         e_i <= '0;
         e_q <= '0;
      end else begin
         if (shift_en) begin
            for (int unsigned n = NTAP - 1; n > 0; n--) begin
               x_i[n] <= x_i[n-1];
               x_q[n] <= x_q[n-1];
            end
            x_i[0] <= din_i;
            x_q[0] <= din_q;
         end
         if (accept_err) begin
            e_i <= err_i;
            e_q <= err_q;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         feed_valid <= 1'b0;
         feed_tag   <= '0;
         feed_xi    <= '0;
         feed_xq    <= '0;
      end else if (state == ST_SWEEP) begin
         feed_valid <= 1'b1;
         feed_tag   <= k;
         feed_xi    <= x_i[k];
         feed_xq    <= x_q[k];
      end else begin
         feed_valid <= 1'b0;
         feed_tag   <= '0;
         feed_xi    <= '0;
         feed_xq    <= '0;
      end
   end

   cmul_conj_sat #(
      .DW    (DW),
      .SHIFT (SHIFT),
      .TW    (TAP_W)
   ) u_cmul (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (feed_valid),
      .in_tag    (feed_tag),
      .e_i       (e_i),
      .e_q       (e_q),
      .x_i       (feed_xi),
      .x_q       (feed_xq),
      .out_valid (grad_valid),
      .out_tag   (grad_tap),
      .out_i     (grad_i),
      .out_q     (grad_q)
   );

endmodule

// File: tb/tb_lms_grad_calc.sv
// Bench for lms_grad_calc: directed and random sweeps against an array model
// of the delay line with plain integer arithmetic for each gradient term.
module tb_lms_grad_calc;

   localparam int N = 32;

   logic               clk = 1'b0;
   logic               reset;
   logic signed [15:0] din_i, din_q, err_i, err_q, grad_i, grad_q;
   logic               din_valid, din_ready, err_valid, err_ready, grad_valid;
   logic [4:0]         grad_tap;

   int n_cmp = 0;
   int n_bad = 0;
   int xm_i [N];
   int xm_q [N];

   always #5 clk = ~clk;

   lms_grad_calc dut (
      .clk        (clk),
      .reset      (reset),
      .din_i      (din_i),
      .din_q      (din_q),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .err_i      (err_i),
      .err_q      (err_q),
      .err_valid  (err_valid),
      .err_ready  (err_ready),
      .grad_i     (grad_i),
      .grad_q     (grad_q),
      .grad_valid (grad_valid),
      .grad_tap   (grad_tap)
   );

   task automatic check_eq(input string tag, input logic signed [63:0] got,
                           input logic signed [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_quiet(input string tag);
      check_eq({tag, ".valid"}, {63'd0, grad_valid}, 0);
      check_eq({tag, ".tap"}, {59'd0, grad_tap}, 0);
      check_eq({tag, ".i"}, $signed(grad_i), 0);
      check_eq({tag, ".q"}, $signed(grad_q), 0);
   endtask

   function automatic longint scale_sat(input longint s);
      longint v;
      v = s >>> 15;
      if (v > 32767) v = 32767;
      else if (v < -32768) v = -32768;
      return v;
   endfunction

   function automatic void model_push(input int xi, input int xq);
      for (int n = N - 1; n > 0; n--) begin
         xm_i[n] = xm_i[n-1];
         xm_q[n] = xm_q[n-1];
      end
      xm_i[0] = xi;
      xm_q[0] = xq;
   endfunction

   function automatic void model_clear();
      for (int n = 0; n < N; n++) begin
         xm_i[n] = 0;
         xm_q[n] = 0;
      end
   endfunction

   task automatic push(input int xi, input int xq);
      @(negedge clk);
      din_i     = 16'(xi);
      din_q     = 16'(xq);
      din_valid = 1'b1;
      @(posedge clk);
      #1;
      din_valid = 1'b0;
      model_push(xi, xq);
   endtask

   // One adaptation: accept err (optionally with a sample), then check the
   // 36 edges that follow. noise drives random strobes during the sweep;
   // abort pulls reset right after tap 10 has been seen.
   task automatic run_sweep(input int ei, input int eq, input bit with_din,
                            input int di, input int dq, input bit noise,
                            input bit abort);
      longint re_exp [N];
      longint im_exp [N];
      logic signed [15:0] r;
      @(negedge clk);
      err_i     = 16'(ei);
      err_q     = 16'(eq);
      err_valid = 1'b1;
      if (with_din) begin
         din_i     = 16'(di);
         din_q     = 16'(dq);
         din_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      err_valid = 1'b0;
      din_valid = 1'b0;
      if (with_din) model_push(di, dq);
      for (int n = 0; n < N; n++) begin
         re_exp[n] = scale_sat(longint'(ei) * xm_i[n] + longint'(eq) * xm_q[n]);
         im_exp[n] = scale_sat(longint'(eq) * xm_i[n] - longint'(ei) * xm_q[n]);
      end
      check_eq("err_ready_after_accept", {63'd0, err_ready}, 0);
      for (int c = 1; c <= 36; c++) begin
         @(posedge clk);
         #1;
         if (c >= 3 && c <= 34) begin
            check_eq("sweep.valid", {63'd0, grad_valid}, 1);
            check_eq("sweep.tap", {59'd0, grad_tap}, c - 3);
            check_eq("sweep.i", $signed(grad_i), re_exp[c-3]);
            check_eq("sweep.q", $signed(grad_q), im_exp[c-3]);
         end else begin
            check_quiet("sweep_gap");
         end
         check_eq("sweep.din_ready", {63'd0, din_ready}, (c >= 34) ? 1 : 0);
         check_eq("sweep.err_ready", {63'd0, err_ready}, (c >= 34) ? 1 : 0);
         if (abort && c == 13) begin
            #2;
            reset = 1'b0;
            #1;
            check_quiet("abort_async");
            check_eq("abort.err_ready", {63'd0, err_ready}, 0);
            break;
         end
         if (noise && c < 30) begin
            r         = 16'($urandom);
            din_i     = r;
            din_q     = 16'($urandom);
            err_i     = 16'($urandom);
            err_q     = 16'($urandom);
            din_valid = 1'($urandom);
            err_valid = 1'($urandom);
         end else begin
            din_valid = 1'b0;
            err_valid = 1'b0;
         end
      end
      if (abort) begin
         repeat (3) begin
            @(negedge clk);
            check_quiet("abort_hold");
         end
         reset = 1'b1;
         model_clear();
         @(posedge clk);
         #1;
         check_eq("abort_release.err_ready", {63'd0, err_ready}, 1);
         for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            check_quiet("abort_after");
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not end, expected completion");
      $fatal(1);
   end

   initial begin
      logic signed [15:0] r1, r2, r3, r4;
      reset     = 1'b0;
      din_valid = 1'b0;
      err_valid = 1'b0;
      din_i = '0; din_q = '0; err_i = '0; err_q = '0;
      model_clear();

      // 1. reset and idle
      repeat (5) begin
         @(negedge clk);
         check_quiet("reset");
         check_eq("reset.din_ready", {63'd0, din_ready}, 0);
      end
      reset = 1'b1;
      #1;
      check_eq("release.ready_before_clk", {63'd0, err_ready}, 0);
      for (int c = 0; c < 4; c++) begin
         @(posedge clk);
         #1;
         check_quiet("idle");
         check_eq("idle.din_ready", {63'd0, din_ready}, 1);
         check_eq("idle.err_ready", {63'd0, err_ready}, 1);
      end

      // 2. single real tap at tap 31
      push(16384, 0);
      repeat (31) push(0, 0);
      run_sweep(16384, 0, 0, 0, 0, 0, 0);

      // 3. conjugate
      push(16384, 0);
      run_sweep(0, 16384, 0, 0, 0, 0, 0);
      push(0, 16384);
      run_sweep(16384, 0, 0, 0, 0, 0, 0);

      // 4. saturation
      push(-32768, -32768);
      run_sweep(-32768, -32768, 0, 0, 0, 0, 0);
      push(-32768, 32767);
      run_sweep(32767, -32768, 0, 0, 0, 0, 0);

      // 5. simultaneous strobes, and strobes during a sweep
      r1 = 16'($urandom); r2 = 16'($urandom);
      run_sweep(12345, -23456, 1, r1, r2, 0, 0);
      r1 = 16'($urandom); r2 = 16'($urandom);
      run_sweep(r1, r2, 0, 0, 0, 1, 0);
      run_sweep(r1, r2, 0, 0, 0, 0, 0);

      // random fill and sweeps
      for (int n = 0; n < 12; n++) begin
         r1 = 16'($urandom); r2 = 16'($urandom);
         push(r1, r2);
      end
      for (int n = 0; n < 6; n++) begin
         r1 = 16'($urandom); r2 = 16'($urandom);
         r3 = 16'($urandom); r4 = 16'($urandom);
         run_sweep(r1, r2, n[0], r3, r4, n[1], 0);
      end

      // 6. reset mid-sweep, then a clean sweep over a zeroed line
      r1 = 16'($urandom); r2 = 16'($urandom);
      run_sweep(r1, r2, 0, 0, 0, 0, 1);
      r1 = 16'($urandom); r2 = 16'($urandom);
      run_sweep(r1, r2, 0, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lms_grad_calc.md
Name: lms_grad_calc

Overview:
- Upstream neighbour of the complex LMS coefficient-update accumulator.
- Holds a 32-tap complex delay line of input samples and latches one complex error sample e per adaptation cycle.
- Per adaptation, streams 32 gradient terms e·conj(x[k]), one per clock, tap 0 first, scaled and saturated to 16 bit.
- Output stream is continuous: the downstream accumulator adds it every clock, so the output is forced to zero whenever no gradient is valid.

Parameters:
- NTAP, 32, delay-line depth and sweep length; must equal downstream shift-register depth.
- DW, 16, I/Q sample, error and gradient width (two's complement).
- SHIFT, 15, arithmetic right shift applied to each 2·DW+1-bit product sum before saturation.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- din_i  in  16  input sample, I.
- din_q  in  16  input sample, Q.
- din_valid  in  1  sample strobe; shifts the delay line when din_ready=1.
- din_ready  out  1  high in IDLE only.
- err_i  in  16  error sample, I.
- err_q  in  16  error sample, Q.
- err_valid  in  1  error strobe; accepted when err_ready=1.
- err_ready  out  1  high in IDLE only.
- grad_i  out  16  gradient term, I; 0 when grad_valid=0.
- grad_q  out  16  gradient term, Q; 0 when grad_valid=0.
- grad_valid  out  1  gradient term valid.
- grad_tap  out  5  tap index of the current gradient term; 0 when invalid.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs, delay line, error latch and counters clear to 0.
  - FSM goes to IDLE; din_ready and err_ready rise on the first clock after reset release.
  - A reset asserted mid-sweep aborts the sweep; no partial terms are issued after release.
- IDLE:
  - din_valid=1: x[k] <= x[k-1] for k=NTAP-1..1, and x[0] <= din.
  - err_valid=1: latch err_i/err_q, clear tap counter, go to SWEEP.
  - Both strobes in the same cycle: the shift and the latch both happen; the sweep uses the updated line, with the new sample at x[0].
- SWEEP:
  - Tap counter k steps 0..NTAP-1, one step per clock.
  - Feeds x[k] and the latched e to the pipeline.
  - After k=NTAP-1 issues, go to DRAIN.
  - din_valid and err_valid are ignored; both ready signals are low.
- DRAIN: wait 2 cycles until the pipeline empties, then go to IDLE.
- Arithmetic, per tap:
  - re = ei·xi + eq·xq
  - im = eq·xi − ei·xq
  - Products are signed 32-bit; sums are 33-bit.
  - Each sum is arithmetically shifted right by SHIFT (truncation toward −inf), then saturated to [−32768, 32767].
- Pipeline: stage 1 registers the four products; stage 2 registers sum/shift/saturate into the outputs.
- Latency and spacing:
  - Term for tap 0 appears with grad_valid=1 on the 3rd rising edge after the edge accepting err_valid.
  - 32 valid terms are consecutive, with no gaps.
  - grad_tap tracks the tap through the pipeline.
- Minimum spacing between err acceptances is NTAP+3 clocks.
- grad_valid=0 outside the 32-cycle window, and grad_i/grad_q read exactly 0.

Decomposition:
- Shared package:
  - NTAP, DW, SHIFT defaults.
  - Tap-index width (clog2 NTAP).
  - FSM state encoding IDLE/SWEEP/DRAIN.
  - Saturation limits.
- One sub-module, cmul_conj_sat: 2-stage pipelined e·conj(x) with shift and saturate. It carries a valid/tag sideband so grad_tap stays aligned.

Test Plan:
1. Reset and idle: hold reset=0 for 5 clocks, then release with no strobes.
   - Required: all outputs 0 throughout; din_ready=err_ready=1 from the first clock after release.
2. Single real tap: shift in x=(16384,0) followed by 31 zeros, so the nonzero sample sits at tap 31; then err=(16384,0).
   - Required: grad_tap 0..31 is output 3..34 clocks after err acceptance.
   - Tap 31 term = (8192,0); all others (0,0); grad_valid high for exactly 32 cycles.
3. Conjugate check: x[0]=(16384,0), err=(0,16384) → tap 0 = (0,8192). Then x[0]=(0,16384), err=(16384,0) → tap 0 = (0,−8192).
4. Saturation: x[0]=(−32768,−32768), err=(−32768,−32768) → tap 0 re saturates to 32767, im = 0. With err=(32767,−32768) and x[0]=(−32768,32767): re = −2147418112, shifts to −65534, so grad_i = −32768 (negative saturation).
5. Simultaneous strobes and blocking:
   - din_valid with err_valid in IDLE: the new sample is used at tap 0.
   - Strobes during SWEEP: ignored, ready=0, delay line unchanged; a later sweep reproduces identical terms.
6. Reset mid-sweep at tap 10: outputs go to 0 asynchronously; no valid terms after release; the next err starts a clean sweep with the line reset to zeros (all terms 0).
